// File: rtl/udma_jtag_fifo_mc_sm.sv
// JTAG data-register bridge: one L-bit scan moves a word into a per-channel rx
// register and/or pops the selected tx stream, with sticky error flags.
module udma_jtag_fifo_mc_sm #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         jtag_tdi_i,
  output logic                         jtag_tdo_o,
  input  logic                         jtag_capture_dr_i,
  input  logic                         jtag_shift_dr_i,
  input  logic                         jtag_update_dr_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_rx_o,
  output logic [NUM_CH-1:0]            data_rx_valid_o,
  input  logic [NUM_CH-1:0]            data_rx_ready_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_tx_i,
  input  logic [NUM_CH-1:0]            data_tx_valid_i,
  output logic [NUM_CH-1:0]            data_tx_ready_o,
  output logic [NUM_CH:0]              err_o,
  input  logic                         err_clr_i
);

  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int L       = DATA_WIDTH + CH_BITS + 2;
  localparam int CNT_W   = $clog2(L + 2);

  // Handshakes: rx data moves when data_rx_valid_o && data_rx_ready_i on a
  // rising edge; data_tx_ready_o is a one-cycle pop strobe, not a ready level.

  logic [L-1:0]                 sr;
  logic [CNT_W-1:0]             bit_cnt;
  logic [CH_BITS-1:0]           ch_sel;
  logic                         cap_valid;
  logic [NUM_CH-1:0]            rx_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] rx_data;
  logic [NUM_CH-1:0]            tx_ready;
  logic [NUM_CH:0]              err;

  logic [DATA_WIDTH-1:0]        sel_tx_data;
  logic                         sel_tx_valid;
  logic                         sel_rx_free;
  logic [NUM_CH-1:0]            rx_free;
  logic [NUM_CH-1:0]            rx_load;
  logic [NUM_CH-1:0]            rx_ovf;
  logic [NUM_CH-1:0]            pop_vec;
  logic [NUM_CH:0]              err_next;

  logic [DATA_WIDTH-1:0]        f_data;
  logic [CH_BITS-1:0]           f_ch;
  logic                         f_wr;
  logic                         f_rd;
  logic                         xfer;
  logic                         ch_ok;
  logic                         bad_ch;

  assign f_data = sr[DATA_WIDTH-1:0];
  assign f_ch   = sr[DATA_WIDTH +: CH_BITS];
  assign f_wr   = sr[L-2];
  assign f_rd   = sr[L-1];

  // Only a scan of exactly L shifts since the last capture is acted upon.
  assign xfer   = jtag_update_dr_i && (bit_cnt == CNT_W'(L));
  assign ch_ok  = ({1'b0, f_ch} < (CH_BITS+1)'(NUM_CH));
  assign bad_ch = xfer && !ch_ok;

  always_comb begin
    sel_tx_data  = '0;
    sel_tx_valid = 1'b0;
    sel_rx_free  = 1'b0;
    rx_free      = '0;
    rx_load      = '0;
    rx_ovf       = '0;
    pop_vec      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rx_free[c] = !rx_valid[c] || data_rx_ready_i[c];
      if (ch_sel == CH_BITS'(c)) begin
        sel_tx_data  = data_tx_i[c*DATA_WIDTH +: DATA_WIDTH];
        sel_tx_valid = data_tx_valid_i[c];
        sel_rx_free  = rx_free[c];
        pop_vec[c]   = xfer && ch_ok && f_rd && cap_valid;
      end
      if (xfer && ch_ok && f_wr && (f_ch == CH_BITS'(c))) begin
        rx_load[c] = rx_free[c];
        rx_ovf[c]  = !rx_free[c];
      end
    end
    // A clear and a new error in the same cycle leave the new error set.
    err_next = (err_clr_i ? '0 : err) | {bad_ch, rx_ovf};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr        <= '0;
      bit_cnt   <= '0;
      ch_sel    <= '0;
      cap_valid <= 1'b0;
    end else if (jtag_capture_dr_i) begin
      sr        <= {sel_rx_free, sel_tx_valid, ch_sel, sel_tx_data};
      cap_valid <= sel_tx_valid;
      bit_cnt   <= '0;
    end else if (jtag_shift_dr_i) begin
      sr <= {jtag_tdi_i, sr[L-1:1]};
      if (bit_cnt != CNT_W'(L + 1)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else if (xfer && ch_ok) begin
      ch_sel <= f_ch;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_valid <= '0;
      rx_data  <= '0;
      tx_ready <= '0;
      err      <= '0;
    end else begin
      tx_ready <= pop_vec;
      err      <= err_next;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rx_load[c]) begin
          rx_data[c*DATA_WIDTH +: DATA_WIDTH] <= f_data;
          rx_valid[c] <= 1'b1;
        end else if (data_rx_ready_i[c]) begin
          rx_valid[c] <= 1'b0;
        end
      end
    end
  end

  assign jtag_tdo_o      = sr[0];
  assign data_rx_o       = rx_data;
  assign data_rx_valid_o = rx_valid;
  assign data_tx_ready_o = tx_ready;
  assign err_o           = err;

endmodule

// File: tb/tb_udma_jtag_fifo_mc_sm.sv
// Bench for udma_jtag_fifo_mc_sm: directed and random JTAG scans checked
// against a transaction-level model of channel registers, pops and errors.
module tb_udma_jtag_fifo_mc_sm;

  localparam int DW  = 32;
  localparam int NC  = 4;
  localparam int L   = 36;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, tdi, cap, shf, upd, err_clr;
  logic            tdo;
  logic [NC*DW-1:0] rx_data, tx_data;
  logic [NC-1:0]   rx_valid, rx_ready, tx_valid, tx_ready;
  logic [NC:0]     err;

  // three-channel build, used for the out-of-range channel index
  logic            tdo3;
  logic [3*DW-1:0] rx_data3;
  logic [3*DW-1:0] tx_data3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  logic [2:0]      rx_valid3, tx_ready3;
  logic [2:0]      rx_ready3 = 3'b000;
  logic [2:0]      tx_valid3 = 3'b111;
  logic [3:0]      err3;

  udma_jtag_fifo_mc_sm #(.DATA_WIDTH(DW), .NUM_CH(NC)) u_dut (
    .clk_i(clk), .rst_i(rst), .jtag_tdi_i(tdi), .jtag_tdo_o(tdo),
    .jtag_capture_dr_i(cap), .jtag_shift_dr_i(shf), .jtag_update_dr_i(upd),
    .data_rx_o(rx_data), .data_rx_valid_o(rx_valid), .data_rx_ready_i(rx_ready),
    .data_tx_i(tx_data), .data_tx_valid_i(tx_valid), .data_tx_ready_o(tx_ready),
    .err_o(err), .err_clr_i(err_clr)
  );

  udma_jtag_fifo_mc_sm #(.DATA_WIDTH(DW), .NUM_CH(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .jtag_tdi_i(tdi), .jtag_tdo_o(tdo3),
    .jtag_capture_dr_i(cap), .jtag_shift_dr_i(shf), .jtag_update_dr_i(upd),
    .data_rx_o(rx_data3), .data_rx_valid_o(rx_valid3), .data_rx_ready_i(rx_ready3),
    .data_tx_i(tx_data3), .data_tx_valid_i(tx_valid3), .data_tx_ready_o(tx_ready3),
    .err_o(err3), .err_clr_i(err_clr)
  );

  // reference model state
  logic [NC-1:0] m_rx_valid;
  logic [DW-1:0] m_rx_data [NC];
  logic [NC:0]   m_err;
  int            m_ch_sel;
  bit            m_cap_valid;
  bit            chk3;
  bit            clr_at_upd;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [NC-1:0] exp_pop);
    logic [NC*DW-1:0] exp_data;
    for (int c = 0; c < NC; c++) exp_data[c*DW +: DW] = m_rx_data[c];
    check({tag, "_rx_valid"}, 128'(rx_valid), 128'(m_rx_valid));
    check({tag, "_rx_data"},  128'(rx_data),  128'(exp_data));
    check({tag, "_err"},      128'(err),      128'(m_err));
    check({tag, "_tx_ready"}, 128'(tx_ready), 128'(exp_pop));
  endtask

  task automatic model_reset();
    m_rx_valid  = '0;
    for (int c = 0; c < NC; c++) m_rx_data[c] = '0;
    m_err       = '0;
    m_ch_sel    = 0;
    m_cap_valid = 1'b0;
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic consume(input int ch);
    rx_ready[ch] = 1'b1;
    @(negedge clk);
    rx_ready = '0;
    m_rx_valid[ch] = 1'b0;
    check_outputs("consume", '0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err = '0;
    check_outputs("err_clr", '0);
  endtask

  // One full DR access: capture, nsh shifts, update with rdy as rx ready.
  task automatic scan(input bit rd, input bit wr, input int ch, input logic [DW-1:0] data,
                      input int nsh, input logic [NC-1:0] rdy);
    logic [L-1:0]  word, cap_exp, got;
    logic [NC-1:0] exp_pop;
    bit            load;
    word    = {rd, wr, 2'(ch), data};
    cap_exp = {~m_rx_valid[m_ch_sel], tx_valid[m_ch_sel], 2'(m_ch_sel), tx_data[m_ch_sel*DW +: DW]};
    m_cap_valid = tx_valid[m_ch_sel];
    cap = 1'b1;
    @(negedge clk);
    cap = 1'b0;
    got = '0;
    for (int i = 0; i < nsh; i++) begin
      if (i < L) got[i] = tdo;
      tdi = (i < L) ? word[i] : 1'($urandom_range(0, 1));
      shf = 1'b1;
      @(negedge clk);
    end
    shf = 1'b0;
    for (int i = nsh; i < L; i++) begin
      got[i]     = 1'b0;
      cap_exp[i] = 1'b0;
    end
    check("tdo_stream", 128'(got), 128'(cap_exp));

    exp_pop = '0;
    load    = 1'b0;
    if (clr_at_upd) m_err = '0;
    if (nsh == L) begin
      if (ch >= NC) begin
        m_err[NC] = 1'b1;
      end else begin
        if (rd && m_cap_valid) exp_pop[m_ch_sel] = 1'b1;
        if (wr) begin
          if (!m_rx_valid[ch] || rdy[ch]) load = 1'b1;
          else m_err[ch] = 1'b1;
        end
        m_ch_sel = ch;
      end
    end
    m_rx_valid = m_rx_valid & ~rdy;
    if (load) begin
      m_rx_valid[ch] = 1'b1;
      m_rx_data[ch]  = data;
    end

    rx_ready = rdy;
    err_clr  = clr_at_upd;
    upd      = 1'b1;
    @(negedge clk);
    upd      = 1'b0;
    rx_ready = '0;
    err_clr  = 1'b0;
    check_outputs("post_update", exp_pop);
    if (chk3) begin
      check("dut3_err",      128'(err3),      128'(4'b1000));
      check("dut3_rx_valid", 128'(rx_valid3), 128'(3'b000));
      check("dut3_tx_ready", 128'(tx_ready3), 128'(3'b000));
    end
    @(negedge clk);
    check_outputs("pop_single", '0);
  endtask

  initial begin
    rst = 1'b1; tdi = 1'b0; cap = 1'b0; shf = 1'b0; upd = 1'b0; err_clr = 1'b0;
    rx_ready = '0; tx_data = '0; tx_valid = '0;
    chk3 = 1'b0; clr_at_upd = 1'b0;
    model_reset();
    do_reset();
    check("reset_tdo", 128'(tdo), 128'(1'b0));
    check_outputs("reset", '0);

    // write channel 2
    scan(1'b0, 1'b1, 2, 32'hDEAD_BEEF, L, '0);
    consume(2);

    // select channel 1, then read it
    scan(1'b0, 1'b0, 1, 32'h0, L, '0);
    tx_data[1*DW +: DW] = 32'h1234_5678;
    tx_valid = 4'b0010;
    scan(1'b1, 1'b0, 1, 32'h0, L, '0);
    tx_valid = '0;

    // overflow on channel 0, then clear with a same-cycle new error on ch3
    scan(1'b0, 1'b1, 0, 32'hAAAA_0001, L, '0);
    scan(1'b0, 1'b1, 0, 32'hBBBB_0002, L, '0);
    scan(1'b0, 1'b1, 3, 32'hCCCC_0003, L, '0);
    clr_at_upd = 1'b1;
    scan(1'b0, 1'b1, 3, 32'hCCCC_0004, L, '0);
    clr_at_upd = 1'b0;
    clear_err();
    consume(0);
    consume(3);

    // short and long scans have no side effects
    tx_valid = 4'b1111;
    scan(1'b1, 1'b1, 1, 32'h5555_5555, L - 1, '0);
    scan(1'b1, 1'b1, 1, 32'h6666_6666, L + 1, '0);
    scan(1'b1, 1'b1, 1, 32'h7777_7777, L + 4, '0);

    // rd with nothing valid at capture does not pop
    tx_valid = '0;
    scan(1'b1, 1'b0, 1, 32'h0, L, '0);

    // consume and reload in the same update cycle
    scan(1'b0, 1'b1, 0, 32'h0000_00C1, L, '0);
    scan(1'b0, 1'b1, 0, 32'h0000_00C2, L, 4'b0001);

    // reset in the middle of a scan
    cap = 1'b1;
    @(negedge clk);
    cap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tdi = 1'b1;
      shf = 1'b1;
      @(negedge clk);
    end
    shf = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    check("midscan_tdo", 128'(tdo), 128'(1'b0));
    check_outputs("midscan", '0);

    // out-of-range channel on the three-channel build
    do_reset();
    tx_valid = '0;
    chk3 = 1'b1;
    scan(1'b1, 1'b1, 3, 32'hBAD0_0003, L, '0);
    chk3 = 1'b0;

    // randomized scans
    for (int it = 0; it < 60; it++) begin
      int sel, nsh;
      for (int c = 0; c < NC; c++) tx_data[c*DW +: DW] = $urandom;
      tx_valid = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 7);
      nsh = (sel == 0) ? L - 1 : (sel == 1) ? L + 1 : (sel == 2) ? L + 3 : L;
      clr_at_upd = ($urandom_range(0, 9) == 0);
      scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, NC - 1),
           $urandom, nsh, 4'($urandom_range(0, 15)));
      clr_at_upd = 1'b0;
      if ($urandom_range(0, 4) == 0) consume($urandom_range(0, NC - 1));
      if ($urandom_range(0, 7) == 0) clear_err();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
